// File: rtl/core_id_scoreboard_pkg.sv
// Shared core package for the ID-stage scoreboard: FSM state names, x0 index
// and small register-index helpers.
package core_id_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_DRAIN  = 2'd2
  } sb_state_e;

  localparam logic [4:0] X0_IDX    = 5'd0;
  localparam int         REG_SPACE = 32;

  function automatic logic [REG_SPACE-1:0] reg_onehot(input logic [4:0] idx);
    return {{(REG_SPACE-1){1'b0}}, 1'b1} << idx;
  endfunction

  // x0 and indices beyond the configured register count are never tracked
  function automatic logic idx_tracked(input logic [4:0] idx, input int nregs);
    return (idx != X0_IDX) && (int'(idx) < nregs);
  endfunction

endpackage

// File: rtl/core_id_scoreboard.sv
// ID-stage register scoreboard: RAW/WAW/structural hazard detection, issue/stall
// generation, pending-write tracking and flush drain. Optional macro CORE_SB_BYPASS_EN
// lets a same-cycle writeback clear a hazard so the instruction issues that cycle.
module core_id_scoreboard
  import core_id_scoreboard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_id_valid,
  input  logic [4:0]                     i_rs1,
  input  logic [4:0]                     i_rs2,
  input  logic [4:0]                     i_rd,
  input  logic                           i_uses_rs1,
  input  logic                           i_uses_rs2,
  input  logic                           i_reg_write,
  input  logic                           i_ex_ready,
  input  logic [4:0]                     i_wb_rd,
  input  logic                           i_wb_reg_write,
  input  logic                           i_flush,
  output logic                           o_issue,
  output logic                           o_stall,
  output logic [NREGS-1:0]               o_busy,
  output logic [$clog2(MAX_OUT+1)-1:0]   o_out_cnt,
  output logic [15:0]                    o_stall_cycles
);

  localparam int            CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  sb_state_e              r_state;
  logic [REG_SPACE-1:0]   r_busy;
  logic [CW-1:0]          r_out_cnt;
  logic [15:0]            r_stall_cycles;

  logic                   w_wb_clr;
  logic [REG_SPACE-1:0]   w_wb_mask;
  logic [REG_SPACE-1:0]   w_busy_view;
  logic [CW-1:0]          w_cnt_view;
  logic                   w_raw;
  logic                   w_waw;
  logic                   w_struct;
  logic                   w_hazard;
  logic                   w_hazard_stall;
  logic                   w_issue;
  logic                   w_set;
  logic [REG_SPACE-1:0]   w_set_mask;

  // Writeback only retires a write that is actually pending.
  assign w_wb_clr  = i_wb_reg_write && (i_wb_rd != X0_IDX) && r_busy[i_wb_rd];
  assign w_wb_mask = w_wb_clr ? reg_onehot(i_wb_rd) : {REG_SPACE{1'b0}};

`ifdef CORE_SB_BYPASS_EN
  assign w_busy_view = r_busy & ~w_wb_mask;
  assign w_cnt_view  = r_out_cnt - {{(CW-1){1'b0}}, w_wb_clr};
`else
  assign w_busy_view = r_busy;
  assign w_cnt_view  = r_out_cnt;
`endif

  assign w_raw    = (i_uses_rs1 && w_busy_view[i_rs1]) || (i_uses_rs2 && w_busy_view[i_rs2]);
  assign w_waw    = i_reg_write && w_busy_view[i_rd];
  assign w_struct = i_reg_write && (i_rd != X0_IDX) && (w_cnt_view == MAX_CNT);
  assign w_hazard = w_raw || w_waw || w_struct;
  assign w_hazard_stall = i_id_valid && w_hazard;

  // HAZARD only records that ID is waiting; issue resumes as soon as the hazard clears.
  assign w_issue = i_id_valid && i_ex_ready && !w_hazard && (r_state != ST_DRAIN) && !i_flush;
  assign w_set      = w_issue && i_reg_write && idx_tracked(i_rd, NREGS);
  assign w_set_mask = w_set ? reg_onehot(i_rd) : {REG_SPACE{1'b0}};

  assign o_issue        = w_issue;
  assign o_stall        = i_id_valid && !w_issue;
  assign o_busy         = r_busy[NREGS-1:0];
  assign o_out_cnt      = r_out_cnt;
  assign o_stall_cycles = r_stall_cycles;

  // Control FSM: flush forces one DRAIN cycle from any state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else if (i_flush) begin
      r_state <= ST_DRAIN;
    end else begin
      case (r_state)
        ST_RUN:    r_state <= w_hazard_stall ? ST_HAZARD : ST_RUN;
        ST_HAZARD: r_state <= w_hazard_stall ? ST_HAZARD : ST_RUN;
        ST_DRAIN:  r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  // Pending-write tracking; a same-register set and clear nets to "still busy".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= {REG_SPACE{1'b0}};
      r_out_cnt <= {CW{1'b0}};
    end else if (i_flush) begin
      r_busy    <= {REG_SPACE{1'b0}};
      r_out_cnt <= {CW{1'b0}};
    end else begin
      r_busy    <= (r_busy & ~w_wb_mask) | w_set_mask;
      r_out_cnt <= r_out_cnt + {{(CW-1){1'b0}}, w_set} - {{(CW-1){1'b0}}, w_wb_clr};
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= 16'd0;
    end else if (o_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

endmodule

// File: tb/tb_core_id_scoreboard.sv
// Self-checking bench for core_id_scoreboard: directed scenarios plus randomized
// traffic against a behavioural scoreboard model (honours CORE_SB_BYPASS_EN).
module tb_core_id_scoreboard;
  import core_id_scoreboard_pkg::*;

  localparam int NREGS   = 32;
  localparam int MAX_OUT = 4;
`ifdef CORE_SB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_id_valid;
  logic [4:0]  i_rs1, i_rs2, i_rd, i_wb_rd;
  logic        i_uses_rs1, i_uses_rs2, i_reg_write, i_ex_ready, i_wb_reg_write, i_flush;
  logic        o_issue, o_stall;
  logic [31:0] o_busy;
  logic [2:0]  o_out_cnt;
  logic [15:0] o_stall_cycles;

  int errors = 0;
  int checks = 0;

  bit        m_busy [32];
  int        m_cnt;
  int        m_stall;
  sb_state_e m_state;

  core_id_scoreboard #(.NREGS(NREGS), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2), .i_reg_write(i_reg_write),
    .i_ex_ready(i_ex_ready), .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write),
    .i_flush(i_flush), .o_issue(o_issue), .o_stall(o_stall), .o_busy(o_busy),
    .o_out_cnt(o_out_cnt), .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic bit m_frees(int r);
    return i_wb_reg_write && (int'(i_wb_rd) == r) && (r != 0) && m_busy[r];
  endfunction

  function automatic bit m_pending(int r);
    return (r != 0) && m_busy[r] && !(BYPASS && m_frees(r));
  endfunction

  function automatic bit m_hazard();
    int inflight;
    bit raw, waw, st;
    inflight = m_cnt - ((BYPASS && m_frees(int'(i_wb_rd))) ? 1 : 0);
    raw = (i_uses_rs1 && m_pending(int'(i_rs1))) || (i_uses_rs2 && m_pending(int'(i_rs2)));
    waw = i_reg_write && m_pending(int'(i_rd));
    st  = i_reg_write && (i_rd != 5'd0) && (inflight == MAX_OUT);
    return raw || waw || st;
  endfunction

  function automatic bit m_issue();
    return i_id_valid && i_ex_ready && !m_hazard() && (m_state != ST_DRAIN) && !i_flush;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = m_busy[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    m_cnt = 0; m_stall = 0; m_state = ST_RUN;
  endtask

  // Advance one clock edge and apply the same edge to the model; ends 1 time unit after it.
  task automatic tick();
    bit iss, hz, vld, fl, we;
    int fr, rd;
    iss = m_issue(); hz = m_hazard(); vld = i_id_valid; fl = i_flush;
    we = i_reg_write; rd = int'(i_rd);
    fr = m_frees(int'(i_wb_rd)) ? int'(i_wb_rd) : -1;
    if (vld && !iss && m_stall < 65535) m_stall++;
    @(posedge i_clk);
    if (fl) begin
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
      m_cnt = 0; m_state = ST_DRAIN;
    end else begin
      if (fr > 0) begin m_busy[fr] = 1'b0; m_cnt--; end
      if (iss && we && rd != 0) begin m_busy[rd] = 1'b1; m_cnt++; end
      m_state = (m_state == ST_DRAIN) ? ST_RUN : ((vld && hz) ? ST_HAZARD : ST_RUN);
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_instr(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we, bit rdy);
    i_id_valid = v; i_rs1 = 5'(rs1); i_uses_rs1 = u1; i_rs2 = 5'(rs2); i_uses_rs2 = u2;
    i_rd = 5'(rd); i_reg_write = we; i_ex_ready = rdy;
  endtask

  task automatic set_wb(bit we, int rd);
    i_wb_reg_write = we; i_wb_rd = 5'(rd);
  endtask

  task automatic idle_inputs();
    set_instr(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    set_wb(1'b0, 0); i_flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    set_instr(1'b1, 3, 1'b1, 4, 1'b1, 6, 1'b1, 1'b1);
    set_wb(1'b0, 0); i_flush = 1'b0;
    #3;
    checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected %h", o_busy, 32'd0); end
    checks++; if (o_out_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", o_out_cnt); end
    checks++; if (o_stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stallcnt: got %0d expected 0", o_stall_cycles); end
    checks++; if (dut.r_state !== ST_RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_RUN); end
    checks++; if (o_issue !== 1'b1 || o_stall !== 1'b0) begin errors++; $display("FAIL reset_issue: got issue=%b stall=%b expected issue=1 stall=0", o_issue, o_stall); end
    do_reset();
  endtask

  task automatic test_raw_hazard();
    do_reset();
    set_instr(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1); #2;
    checks++; if (o_issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b expected 1", o_issue); end
    tick();
    checks++; if (o_busy[5] !== 1'b1 || o_out_cnt !== 3'd1) begin errors++; $display("FAIL raw_busy_set: got busy5=%b cnt=%0d expected busy5=1 cnt=1", o_busy[5], o_out_cnt); end
    set_instr(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1); #2;
    checks++; if (o_stall !== 1'b1 || o_issue !== 1'b0) begin errors++; $display("FAIL raw_stall: got stall=%b issue=%b expected stall=1 issue=0", o_stall, o_issue); end
    tick();
    checks++; if (dut.r_state !== ST_HAZARD) begin errors++; $display("FAIL raw_state_hazard: got %0d expected %0d", dut.r_state, ST_HAZARD); end
    #1; set_wb(1'b1, 5); #1;
    checks++; if (o_issue !== BYPASS) begin errors++; $display("FAIL raw_wb_same_cycle: got %b expected %b", o_issue, BYPASS); end
    tick(); set_wb(1'b0, 0); #2;
    checks++; if (o_issue !== 1'b1) begin errors++; $display("FAIL raw_issue_after_wb: got %b expected 1", o_issue); end
    checks++; if (o_busy !== 32'd0 || o_out_cnt !== 3'd0) begin errors++; $display("FAIL raw_cleared: got busy=%h cnt=%0d expected 0/0", o_busy, o_out_cnt); end
    tick();
  endtask

  task automatic test_structural();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, r, 1'b1, 1'b1); #2;
      checks++; if (o_issue !== 1'b1) begin errors++; $display("FAIL struct_fill_issue: rd=%0d got %b expected 1", r, o_issue); end
      tick();
    end
    checks++; if (o_out_cnt !== 3'd4 || o_busy !== 32'h1E) begin errors++; $display("FAIL struct_full: got cnt=%0d busy=%h expected 4/0000001e", o_out_cnt, o_busy); end
    set_instr(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b1); #2;
    checks++; if (o_stall !== 1'b1 || o_issue !== 1'b0) begin errors++; $display("FAIL struct_stall: got stall=%b issue=%b expected 1/0", o_stall, o_issue); end
    tick(); set_wb(1'b1, 1); #2;
    checks++; if (o_issue !== BYPASS) begin errors++; $display("FAIL struct_wb_same: got %b expected %b", o_issue, BYPASS); end
    tick(); set_wb(1'b0, 0); #2;
    // with bypass rd=6 already issued, so re-presenting it now hits WAW
    checks++; if (o_issue !== !BYPASS) begin errors++; $display("FAIL struct_wb_next: got %b expected %b", o_issue, !BYPASS); end
    tick();
    checks++; if (o_out_cnt !== 3'd4 || o_busy[6] !== 1'b1) begin errors++; $display("FAIL struct_refill: got cnt=%0d busy6=%b expected 4/1", o_out_cnt, o_busy[6]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 7; r <= 9; r++) begin
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, r, 1'b1, 1'b1); tick();
    end
    checks++; if (o_busy !== 32'h380 || o_out_cnt !== 3'd3) begin errors++; $display("FAIL flush_pre: got busy=%h cnt=%0d expected 00000380/3", o_busy, o_out_cnt); end
    set_instr(1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b1); set_wb(1'b1, 7); i_flush = 1'b1; #2;
    checks++; if (o_issue !== 1'b0) begin errors++; $display("FAIL flush_issue: got %b expected 0", o_issue); end
    tick(); i_flush = 1'b0; set_wb(1'b0, 0);
    checks++; if (o_busy !== 32'd0 || o_out_cnt !== 3'd0) begin errors++; $display("FAIL flush_clear: got busy=%h cnt=%0d expected 0/0", o_busy, o_out_cnt); end
    checks++; if (dut.r_state !== ST_DRAIN) begin errors++; $display("FAIL flush_drain_state: got %0d expected %0d", dut.r_state, ST_DRAIN); end
    #2;
    checks++; if (o_issue !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL flush_drain_issue: got issue=%b stall=%b expected 0/1", o_issue, o_stall); end
    tick();
    checks++; if (dut.r_state !== ST_RUN) begin errors++; $display("FAIL flush_run_state: got %0d expected %0d", dut.r_state, ST_RUN); end
    #2;
    checks++; if (o_issue !== 1'b1) begin errors++; $display("FAIL flush_resume: got %b expected 1", o_issue); end
    tick();
  endtask

  task automatic test_x0_nonbusy();
    do_reset();
    set_instr(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b1); #2;
    checks++; if (o_issue !== 1'b1) begin errors++; $display("FAIL x0_issue: got %b expected 1", o_issue); end
    tick();
    checks++; if (o_busy !== 32'd0 || o_out_cnt !== 3'd0) begin errors++; $display("FAIL x0_write: got busy=%h cnt=%0d expected 0/0", o_busy, o_out_cnt); end
    set_instr(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1); tick();
    idle_inputs(); set_wb(1'b1, 0); tick();
    checks++; if (o_busy !== 32'h8 || o_out_cnt !== 3'd1) begin errors++; $display("FAIL x0_wb: got busy=%h cnt=%0d expected 00000008/1", o_busy, o_out_cnt); end
    set_wb(1'b1, 10); tick();
    checks++; if (o_busy !== 32'h8 || o_out_cnt !== 3'd1) begin errors++; $display("FAIL nonbusy_wb: got busy=%h cnt=%0d expected 00000008/1", o_busy, o_out_cnt); end
    set_wb(1'b1, 3); tick(); set_wb(1'b0, 0);
    checks++; if (o_busy !== 32'd0 || o_out_cnt !== 3'd0) begin errors++; $display("FAIL busy_wb: got busy=%h cnt=%0d expected 0/0", o_busy, o_out_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_instr(1'b1, 0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b1); tick();
    set_instr(1'b1, 0, 1'b0, 12, 1'b1, 0, 1'b0, 1'b1); tick();
    checks++; if (dut.r_state !== ST_HAZARD || o_stall_cycles !== 16'd1) begin errors++; $display("FAIL areset_pre: got state=%0d stallcnt=%0d expected %0d/1", dut.r_state, o_stall_cycles, ST_HAZARD); end
    #1; i_rst_n = 1'b0; #1;
    checks++; if (o_busy !== 32'd0 || o_out_cnt !== 3'd0 || o_stall_cycles !== 16'd0) begin errors++; $display("FAIL areset_clear: got busy=%h cnt=%0d stallcnt=%0d expected 0/0/0", o_busy, o_out_cnt, o_stall_cycles); end
    checks++; if (dut.r_state !== ST_RUN) begin errors++; $display("FAIL areset_state: got %0d expected %0d", dut.r_state, ST_RUN); end
    idle_inputs(); #2; i_rst_n = 1'b1; model_reset();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_instr(($urandom % 8) != 0, $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2,
                $urandom % 8, ($urandom % 4) != 0, ($urandom % 5) != 0);
      set_wb(($urandom % 3) == 0, $urandom % 8);
      i_flush = (($urandom % 24) == 0);
      #2;
      checks++; if (o_issue !== m_issue() || o_stall !== (i_id_valid && !m_issue())) begin errors++; $display("FAIL rand_issue[%0d]: got issue=%b stall=%b expected issue=%b stall=%b", n, o_issue, o_stall, m_issue(), i_id_valid && !m_issue()); end
      tick();
      checks++; if (o_busy !== m_busy_vec() || int'(o_out_cnt) != m_cnt) begin errors++; $display("FAIL rand_busy[%0d]: got busy=%h cnt=%0d expected busy=%h cnt=%0d", n, o_busy, o_out_cnt, m_busy_vec(), m_cnt); end
      checks++; if (int'(o_stall_cycles) != m_stall || dut.r_state !== m_state) begin errors++; $display("FAIL rand_state[%0d]: got stallcnt=%0d state=%0d expected %0d/%0d", n, o_stall_cycles, dut.r_state, m_stall, m_state); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raw_hazard();
    test_structural();
    test_flush();
    test_x0_nonbusy();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
